fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter sharing the write side of the async FIFO (`top`) between `NUM_REQ` producers in the `wr_clk` domain. It grants one requester at a time for a burst of up to `MAX_BURST` beats. It drives `wr_en`/`din` into the FIFO and never issues a write while `full` is high. It also keeps a running count of accepted writes for debug and bring-up.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `FIFO_WIDTH`, 16: data width; must match the FIFO's `FIFO_WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant; must be ≥ 1.
- `wr_clk`  in  1  FIFO write clock; the only clock in this block.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-requester data valid.
- `req_data`  in  NUM_REQ*FIFO_WIDTH  requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_din`  out  FIFO_WIDTH  to FIFO `din`.
- `grant_id`  out  max(1,$clog2(NUM_REQ))  currently or last granted requester.
- `busy`  out  1  high while in BURST.
- `wr_count`  out  16  accepted beats, wraps modulo 2^16.

## Operation
- State machine has two states, IDLE and BURST. State, `grant_id`, `last_grant`, `beat_cnt` and `wr_count` are registers.
- **IDLE**: if any `req_valid` is high, pick the first valid requester, searching from `last_grant+1` upward with wrap. Load `grant_id`, clear `beat_cnt`, and go to BURST. If no request is valid, stay in IDLE.
- **BURST**: beat when `req_valid[grant_id] && !fifo_full`.
- `fifo_wr_en = busy && req_valid[grant_id] && !fifo_full` (combinational).
- `req_ready[i] = busy && (i==grant_id) && !fifo_full`.
- `fifo_din = req_data[grant_id]` whenever `busy`, else 0.
- On each beat, `beat_cnt` increments and `wr_count` increments.
- Release to IDLE, setting `last_grant <= grant_id`, when either:
  - a beat occurs with `beat_cnt == MAX_BURST-1`, or
  - `req_valid[grant_id]` is low while `fifo_full` is low (requester ends early).
- `fifo_full` high stalls the burst. The grant is held and `beat_cnt` is frozen; full alone never releases a grant.
- The requester protocol is valid/ready. Data must stay stable while valid is high and ready is low.

## Timing
- Reset (async, immediate) values:
  - state IDLE, `busy` 0, `fifo_wr_en` 0, `req_ready` 0, `fifo_din` 0
  - `grant_id` 0, `last_grant` NUM_REQ-1 (requester 0 has first priority)
  - `beat_cnt` 0, `wr_count` 0
- Arbitration latency: 1 cycle. `req_valid` sampled in IDLE at edge N gives a possible beat in cycle N+1.
- Turnaround: exactly one IDLE cycle between consecutive grants, even when other requests are pending.
- A full uncontested burst of MAX_BURST beats occupies MAX_BURST consecutive cycles. Steady-state throughput is MAX_BURST/(MAX_BURST+1).
- Full feedback: no registered path sits between `fifo_full` and `fifo_wr_en`, so no write is issued in any cycle where `full` is high.
- MAX_BURST = 1: every beat releases the grant.
- Reset asserted mid-burst: outputs drop immediately. No partial state survives. After deassertion, arbitration restarts from requester 0.
- `wr_count` wraps from 0xFFFF to 0x0000 without a flag.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `{ARB_IDLE, ARB_BURST}`
  - width helper function for `grant_id` and `beat_cnt` (`max(1,$clog2(x))`)
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, `last_grant`.
  - Outputs: `pick_id`, `pick_valid`.
  - Its search order is the only place priority is defined.

## Test plan
- **Reset mid-burst:** req0 valid, assert `rst_n`=0 during beat 2 -> `fifo_wr_en`, `req_ready`, `busy` and `wr_count` are 0 in the same timestep. After release, req0 and req1 valid -> req0 granted first.
- **Single requester:** req1 valid continuously with data 0x1000, 0x1001, … -> 4 beats, 1 idle cycle, 4 beats. `fifo_din` is consecutive, `grant_id`=1 throughout, and `wr_count`=8 after 10 cycles.
- **All valid:** all four requesters valid continuously -> grant order 0,1,2,3,0, 4 beats each. `wr_count`=16 after the 4th burst completes.
- **Full stall:** force `fifo_full`=1 for 3 cycles after beat 2 of req0 -> `fifo_wr_en`=0 and `req_ready`=0 during the stall, `grant_id` held, then exactly 2 more beats before release.
- **Early drop:** req2 deasserts valid after 2 beats, `fifo_full`=0, req3 valid -> release and req3 granted after 1 IDLE cycle. req2's third word is never written.
- **Integration with the async FIFO `top`:** 3 requesters writing tagged sequences and a slower `rd_clk` draining -> per-requester data arrives in order, nothing is lost or duplicated, and no `wr_en` occurs while `full` is high.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  // Width of an index over n items; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after last_grant+1, with wrap.
// This search order is the single definition of arbitration priority.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    last_grant_i,
  output logic [IdW-1:0]    pick_id_o,
  output logic              pick_valid_o
);

  // Walk the requesters starting just after the previous winner; the first hit wins.
  always_comb begin
    logic [IdW-1:0] idx;
    idx          = '0;
    pick_id_o    = '0;
    pick_valid_o = 1'b0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      idx = IdW'((32'(last_grant_i) + off) % NumReq);
      if (!pick_valid_o && req_i[idx]) begin
        pick_valid_o = 1'b1;
        pick_id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ producers.
// A grant lasts up to MAX_BURST beats; fifo_full gates writes combinationally.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned GntW = idx_width(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_din,
  output logic [GntW-1:0]               grant_id,
  output logic                          busy,
  output logic [15:0]                   wr_count
);

  localparam int unsigned BeatW = idx_width(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic [GntW-1:0] grant_q, grant_d;
  logic [GntW-1:0] last_grant_q, last_grant_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]     wr_count_q, wr_count_d;

  logic [FIFO_WIDTH-1:0] data_arr [NUM_REQ];
  logic [GntW-1:0]       pick_id;
  logic                  pick_valid;
  logic                  cur_valid;
  logic                  beat;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  rr_pick #(
    .NumReq (NUM_REQ)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .pick_id_o    (pick_id),
    .pick_valid_o (pick_valid)
  );

  // Write-side outputs; fifo_full reaches fifo_wr_en with no register in between.
  always_comb begin
    busy       = (state_q == ARB_BURST);
    cur_valid  = req_valid[grant_q];
    beat       = busy && cur_valid && !fifo_full;
    fifo_wr_en = beat;
    req_ready  = '0;
    if (busy && !fifo_full) req_ready[grant_q] = 1'b1;
    fifo_din   = busy ? data_arr[grant_q] : '0;
    grant_id   = grant_q;
    wr_count   = wr_count_q;
  end

  // Next-state: arbitrate in IDLE, count beats in BURST, release on last beat or early drop.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    wr_count_d   = wr_count_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_id;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (beat) begin
          wr_count_d = wr_count_q + 16'd1;
          beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (beat_cnt_q == BeatW'(MAX_BURST - 1)) begin
            state_d      = ARB_IDLE;
            last_grant_d = grant_q;
          end
        end else if (!cur_valid && !fifo_full) begin
          // Requester ended early; a full FIFO alone never releases the grant.
          state_d      = ARB_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; last_grant resets to the top so requester 0 wins first.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= GntW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_count_q   <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle table plus reset and round-robin sequences.
// Written words are checked through an expected-write queue.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic            wr_clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_din;
  logic [1:0]      grant_id;
  logic            busy;
  logic [15:0]     wr_count;

  logic [W-1:0] data_arr [NR];

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .FIFO_WIDTH (W),
    .MAX_BURST  (MB)
  ) dut (
    .wr_clk     (wr_clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy),
    .wr_count   (wr_count)
  );

  always #5 wr_clk = ~wr_clk;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_data[g*W +: W] = data_arr[g];
  end

  typedef struct {
    logic [3:0]  valid;
    logic        full;
    logic        wr;
    logic [3:0]  ready;
    logic        busy;
    logic [1:0]  gid;
    logic [15:0] cnt;
    logic [15:0] din;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          seq [NR];
  int          snap [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Producer i presents tag i in the top nibble and its sequence number below.
  task automatic refresh_data();
    for (int i = 0; i < NR; i++) data_arr[i] = 16'(i * 4096 + (seq[i] % 4096));
  endtask

  task automatic check_outputs(input string tag, input logic w, input logic [3:0] r,
                               input logic b, input logic [1:0] g, input logic [15:0] c,
                               input logic [15:0] d);
    chk({tag, " wr_en"},    32'(fifo_wr_en), 32'(w));
    chk({tag, " req_ready"}, 32'(req_ready), 32'(r));
    chk({tag, " busy"},     32'(busy),       32'(b));
    chk({tag, " grant_id"}, 32'(grant_id),   32'(g));
    chk({tag, " wr_count"}, 32'(wr_count),   32'(c));
    chk({tag, " fifo_din"}, 32'(fifo_din),   32'(d));
  endtask

  // Scoreboard pop on each write, then advance to 1 time unit past the next rising edge.
  task automatic finish_cycle();
    logic [NR-1:0] hs;
    logic [15:0]   e;
    hs = req_valid & req_ready;
    if (fifo_wr_en === 1'b1) begin
      chk("no_write_while_full", 32'(fifo_full), 32'(0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write: got din %0h expected no write", fifo_din);
      end else begin
        e = exp_q.pop_front();
        chk("sb_din", 32'(fifo_din), 32'(e));
      end
    end
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) seq[i]++;
    refresh_data();
  endtask

  task automatic add(input logic [3:0] v, input logic f, input logic w, input logic [3:0] r,
                     input logic b, input logic [1:0] g, input int c, input logic [15:0] d);
    vec_t t;
    t.valid = v; t.full = f; t.wr = w; t.ready = r;
    t.busy = b; t.gid = g; t.cnt = 16'(c); t.din = d;
    vecs.push_back(t);
  endtask

  initial begin
    int          r;
    logic [1:0]  gi;
    logic [15:0] d;

    // Single requester 1: two full bursts separated by one idle cycle.
    add(4'b0010, 0, 0, 4'b0000, 0, 2'd0, 0, 16'h0000);
    for (int b = 0; b < 4; b++) add(4'b0010, 0, 1, 4'b0010, 1, 2'd1, b, 16'(16'h1000 + b));
    add(4'b0010, 0, 0, 4'b0000, 0, 2'd1, 4, 16'h0000);
    for (int b = 0; b < 4; b++) add(4'b0010, 0, 1, 4'b0010, 1, 2'd1, 4 + b, 16'(16'h1004 + b));
    add(4'b0000, 0, 0, 4'b0000, 0, 2'd1, 8, 16'h0000);
    // Requester 0 with a three-cycle full stall after beat 2.
    add(4'b0001, 0, 0, 4'b0000, 0, 2'd1, 8, 16'h0000);
    add(4'b0001, 0, 1, 4'b0001, 1, 2'd0, 8, 16'h0000);
    add(4'b0001, 0, 1, 4'b0001, 1, 2'd0, 9, 16'h0001);
    for (int s = 0; s < 3; s++) add(4'b0001, 1, 0, 4'b0000, 1, 2'd0, 10, 16'h0002);
    add(4'b0001, 0, 1, 4'b0001, 1, 2'd0, 10, 16'h0002);
    add(4'b0001, 0, 1, 4'b0001, 1, 2'd0, 11, 16'h0003);
    add(4'b0000, 0, 0, 4'b0000, 0, 2'd0, 12, 16'h0000);
    // Requester 2 drops after two beats; requester 3 follows after one idle cycle.
    add(4'b1100, 0, 0, 4'b0000, 0, 2'd0, 12, 16'h0000);
    add(4'b1100, 0, 1, 4'b0100, 1, 2'd2, 12, 16'h2000);
    add(4'b1100, 0, 1, 4'b0100, 1, 2'd2, 13, 16'h2001);
    add(4'b1000, 0, 0, 4'b0100, 1, 2'd2, 14, 16'h2002);
    add(4'b1000, 0, 0, 4'b0000, 0, 2'd2, 14, 16'h0000);
    add(4'b1000, 0, 1, 4'b1000, 1, 2'd3, 14, 16'h3000);
    add(4'b0000, 0, 0, 4'b1000, 1, 2'd3, 15, 16'h3001);
    add(4'b0000, 0, 0, 4'b0000, 0, 2'd3, 15, 16'h0000);

    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) seq[i] = 0;
    refresh_data();
    repeat (2) @(posedge wr_clk);
    #1;
    req_valid = 4'b1111;
    #1;
    check_outputs("reset", 0, 4'b0000, 0, 2'd0, 16'd0, 16'h0000);
    req_valid = '0;
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req_valid = vecs[i].valid;
      fifo_full = vecs[i].full;
      if (vecs[i].wr) exp_q.push_back(vecs[i].din);
      #4;
      check_outputs($sformatf("row%0d", i), vecs[i].wr, vecs[i].ready, vecs[i].busy,
                    vecs[i].gid, vecs[i].cnt, vecs[i].din);
      finish_cycle();
    end

    // Reset during beat 2 of a requester-0 burst.
    req_valid = 4'b0001;
    #4;
    check_outputs("rst_h1", 0, 4'b0000, 0, 2'd3, 16'd15, 16'h0000);
    finish_cycle();
    exp_q.push_back(16'h0004);
    #4;
    check_outputs("rst_h2", 1, 4'b0001, 1, 2'd0, 16'd15, 16'h0004);
    finish_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs("rst_mid", 0, 4'b0000, 0, 2'd0, 16'd0, 16'h0000);
    finish_cycle();
    rst_n     = 1'b1;
    req_valid = 4'b0011;
    #4;
    check_outputs("rst_after_idle", 0, 4'b0000, 0, 2'd0, 16'd0, 16'h0000);
    finish_cycle();
    exp_q.push_back(16'h0005);
    #4;
    check_outputs("rst_after_gnt", 1, 4'b0001, 1, 2'd0, 16'd0, 16'h0005);
    finish_cycle();
    req_valid = '0;
    #4;
    check_outputs("rst_after_drop", 0, 4'b0001, 1, 2'd0, 16'd1, 16'h0006);
    finish_cycle();
    #4;
    check_outputs("rst_after_rel", 0, 4'b0000, 0, 2'd0, 16'd1, 16'h0000);
    finish_cycle();

    // All four valid from reset: grants 0,1,2,3,0 with one idle cycle between bursts.
    #1;
    rst_n = 1'b0;
    finish_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) snap[i] = seq[i];
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gi = (k == 0) ? 2'd0 : 2'((k - 1) % 4);
      #4;
      check_outputs($sformatf("rr_idle%0d", k), 0, 4'b0000, 0, gi, 16'(4 * k), 16'h0000);
      finish_cycle();
      for (int b = 0; b < 4; b++) begin
        r = k % 4;
        d = 16'(r * 4096 + snap[r] + (k / 4) * 4 + b);
        exp_q.push_back(d);
        #4;
        check_outputs($sformatf("rr_k%0d_b%0d", k, b), 1, 4'(1 << r), 1, 2'(r),
                      16'(4 * k + b), d);
        finish_cycle();
      end
    end
    #4;
    check_outputs("rr_end", 0, 4'b0000, 0, 2'd0, 16'd20, 16'h0000);
    req_valid = '0;
    finish_cycle();

    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
